// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle control FSM for a 16-bit CR16-style datapath. It fetches an
// instruction, decodes it, and drives the ALU operation, register-file
// addresses, immediate/writeback/PC selects and the memory handshake. It also
// owns the architectural PSR and evaluates Jcond/Bcond conditions from it.
//
// Instruction encoding assumes WIDTH = 16: op = ir[15:12], cond/Rdest =
// ir[11:8], ext = ir[7:4], Rsrc/Raddr = ir[3:0].
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   instr      in   memory read data, captured into ir_out in FETCH
//   mem_ready  in   memory completes the current request this cycle
//   psr_flags  in   ALU flags: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N
//   mem_req    out  memory request valid
//   mem_we     out  memory write (STOR)
//   addr_sel   out  0: address = PC, 1: address = R[rb_addr]
//   ir_out     out  instruction register
//   alu_cont   out  ALU operation select (non-zero only in EXEC)
//   imm_sel    out  ALU b operand comes from the immediate field
//   ra_addr    out  ir[11:8] (Rdest)
//   rb_addr    out  ir[3:0]  (Rsrc/Raddr)
//   reg_write  out  register file write strobe
//   wb_sel     out  0: ALU, 1: memory data, 2: PC+1
//   pc_en      out  PC update strobe
//   pc_src     out  0: PC+1, 1: PC+sext(disp8), 2: R[rb_addr]
//   psr        out  latched PSR, same layout as psr_flags
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         instr,
  input  logic                     mem_ready,
  input  logic [WIDTH-1:0]         psr_flags,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     addr_sel,
  output logic [WIDTH-1:0]         ir_out,
  output logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic                     imm_sel,
  output logic [REG_ADDR_BITS-1:0] ra_addr,
  output logic [REG_ADDR_BITS-1:0] rb_addr,
  output logic                     reg_write,
  output logic [1:0]               wb_sel,
  output logic                     pc_en,
  output logic [1:0]               pc_src,
  output logic [WIDTH-1:0]         psr
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_BRANCH
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_N = 7;

  state_t state, state_next;

  // Set on the first clock edge after reset is released. It keeps FETCH from
  // requesting memory during the release cycle, so mem_req first rises one
  // edge later and drops asynchronously whenever reset is asserted.
  logic started;

  // ---------------------------------------------------------------------------
  // Instruction decode (from the latched instruction register)
  // ---------------------------------------------------------------------------
  logic [3:0] op, ext, cond;
  logic       rr_alu, imm_alu, is_lui, is_load, is_stor, is_jal, is_jcond, is_bcond;
  logic [3:0] alu_code;
  logic       is_cmp, loads_cf, cond_true;

  // The eight ALU codes shared by the register-register ext field and the
  // immediate-form opcode field.
  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD};
  endfunction

  assign op   = ir_out[15:12];
  assign cond = ir_out[11:8];
  assign ext  = ir_out[7:4];

  assign ra_addr = ir_out[8 +: REG_ADDR_BITS];
  assign rb_addr = ir_out[0 +: REG_ADDR_BITS];

  assign rr_alu   = (op == 4'h0) && is_alu_code(ext);
  assign imm_alu  = is_alu_code(op);
  assign is_lui   = (op == 4'hF);
  assign is_load  = (op == 4'h4) && (ext == 4'h0);
  assign is_stor  = (op == 4'h4) && (ext == 4'h4);
  assign is_jal   = (op == 4'h4) && (ext == 4'h8);
  assign is_jcond = (op == 4'h4) && (ext == 4'hC);
  assign is_bcond = (op == 4'hC);

  // Register-register ops carry their ALU code in ext, immediate ops in op.
  assign alu_code = rr_alu ? ext : op;
  assign is_cmp   = (rr_alu || imm_alu) && (alu_code == 4'hB);
  assign loads_cf = (rr_alu || imm_alu) && ((alu_code == 4'h5) || (alu_code == 4'h9));

  always_comb begin
    unique case (cond)
      4'h0:    cond_true =  psr[FLAG_Z];
      4'h1:    cond_true = !psr[FLAG_Z];
      4'h2:    cond_true =  psr[FLAG_C];
      4'h3:    cond_true = !psr[FLAG_C];
      4'h4:    cond_true =  psr[FLAG_L];
      4'h5:    cond_true = !psr[FLAG_L];
      4'h6:    cond_true =  psr[FLAG_N];
      4'h7:    cond_true = !psr[FLAG_N];
      4'h8:    cond_true =  psr[FLAG_F];
      4'h9:    cond_true = !psr[FLAG_F];
      4'hA:    cond_true = !psr[FLAG_L] && !psr[FLAG_Z];
      4'hB:    cond_true =  psr[FLAG_L] ||  psr[FLAG_Z];
      4'hC:    cond_true = !psr[FLAG_N] && !psr[FLAG_Z];
      4'hD:    cond_true =  psr[FLAG_N] ||  psr[FLAG_Z];
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, instruction register and PSR
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      started <= 1'b0;
      ir_out  <= '0;
      psr     <= '0;
    end else begin
      started <= 1'b1;
      state   <= state_next;
      if ((state == S_FETCH) && started && mem_ready) begin
        ir_out <= instr;
      end
      // Flags are committed only on the EXEC edge, and only the bits owned
      // by the executing instruction class.
      if (state == S_EXEC) begin
        if (loads_cf) begin
          psr[FLAG_C] <= psr_flags[FLAG_C];
          psr[FLAG_F] <= psr_flags[FLAG_F];
        end
        if (is_cmp) begin
          psr[FLAG_N] <= psr_flags[FLAG_N];
          psr[FLAG_Z] <= psr_flags[FLAG_Z];
          psr[FLAG_L] <= psr_flags[FLAG_L];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path through the
  // block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    alu_cont   = '0;
    imm_sel    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'd0;
    pc_en      = 1'b0;
    pc_src     = 2'd0;

    unique case (state)
      S_FETCH: begin
        if (started) begin
          mem_req = 1'b1;
          if (mem_ready) state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (rr_alu || imm_alu || is_lui) begin
          state_next = S_EXEC;
        end else if (is_load || is_stor) begin
          state_next = S_MEM;
        end else if (is_jal || is_jcond || is_bcond) begin
          state_next = S_BRANCH;
        end else begin
          // Unrecognised encodings retire as a NOP.
          pc_en      = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_cont   = is_lui ? '1 : ALU_CONT_BITS'(alu_code);
        imm_sel    = imm_alu || is_lui;
        reg_write  = !is_cmp;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_stor;
        if (mem_ready) begin
          reg_write  = is_load;
          wb_sel     = is_load ? 2'd1 : 2'd0;
          pc_en      = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_BRANCH: begin
        pc_en      = 1'b1;
        state_next = S_FETCH;
        if (is_jal) begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          pc_src    = 2'd2;
        end else if (is_jcond && cond_true) begin
          pc_src = 2'd2;
        end else if (is_bcond && cond_true) begin
          pc_src = 2'd1;
        end
      end

      default: state_next = S_FETCH;
    endcase
  end

  // Flag bits the sequencer never latches.
  logic unused_flags;
  assign unused_flags = ^{psr_flags[WIDTH-1:8], psr_flags[4:3], psr_flags[1]};

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer. Each task drives one scenario and checks
// the control outputs, instruction register and PSR against hand-computed
// values. Outputs are sampled 1 ns or more after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic [15:0] psr_flags;
  logic        mem_req, mem_we, addr_sel, imm_sel, reg_write, pc_en;
  logic [15:0] ir_out, psr;
  logic [5:0]  alu_cont;
  logic [3:0]  ra_addr, rb_addr;
  logic [1:0]  wb_sel, pc_src;

  int compared   = 0;
  int mismatched = 0;
  logic [16:0] want;

  alu_sequencer #(.WIDTH(16), .ALU_CONT_BITS(6), .REG_ADDR_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ready (mem_ready),
    .psr_flags (psr_flags),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_out    (ir_out),
    .alu_cont  (alu_cont),
    .imm_sel   (imm_sel),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .pc_en     (pc_en),
    .pc_src    (pc_src),
    .psr       (psr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control outputs packed as
  // {mem_req, mem_we, addr_sel, reg_write, wb_sel, pc_en, pc_src, imm_sel, alu_cont}
  function automatic logic [16:0] ctrl();
    return {mem_req, mem_we, addr_sel, reg_write, wb_sel, pc_en, pc_src, imm_sel, alu_cont};
  endfunction

  function automatic logic [16:0] mk(input logic mreq, input logic mwe, input logic asel,
                                     input logic rw, input logic [1:0] wb, input logic pen,
                                     input logic [1:0] psrc, input logic imm,
                                     input logic [5:0] ac);
    return {mreq, mwe, asel, rw, wb, pen, psrc, imm, ac};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present an instruction with mem_ready=1 for one edge.
  task automatic run_fetch(input logic [15:0] v);
    instr     = v;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    compared++;
    if (ctrl() !== 17'd0) begin
      mismatched++; $display("FAIL reset_ctrl: got %h want 0", ctrl());
    end
    compared++;
    if (psr !== 16'h0000 || ir_out !== 16'h0000) begin
      mismatched++; $display("FAIL reset_regs: psr %h ir %h want 0/0", psr, ir_out);
    end
    reset = 1'b1; instr = 16'h0251; mem_ready = 1'b1;
    #1;
    compared++;
    if (mem_req !== 1'b0) begin
      mismatched++; $display("FAIL release_no_req: mem_req %b want 0", mem_req);
    end
    tick();
    compared++;
    if (ctrl() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++; $display("FAIL first_fetch: got %h want %h", ctrl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    tick();
    mem_ready = 1'b0;
    compared++;
    if (ir_out !== 16'h0251 || ctrl() !== 17'd0) begin
      mismatched++; $display("FAIL add_decode: ir %h ctrl %h want 0251/0", ir_out, ctrl());
    end
    tick();
    psr_flags = 16'h00E5;
    #1;
    want = mk(0, 0, 0, 1, 0, 1, 0, 0, 6'b000101);
    compared++;
    if (ctrl() !== want || ra_addr !== 4'd2 || rb_addr !== 4'd1) begin
      mismatched++; $display("FAIL add_exec: ctrl %h ra %0d rb %0d want %h ra 2 rb 1", ctrl(), ra_addr, rb_addr, want);
    end
    tick();
    psr_flags = 16'h0000;
    compared++;
    if (psr !== 16'h0021) begin
      mismatched++; $display("FAIL add_psr: got %h want 0021", psr);
    end
  endtask

  task automatic test_fetch_wait();
    instr = 16'h1305;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (ctrl() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0) || ir_out !== 16'h0251) begin
        mismatched++; $display("FAIL fetch_wait[%0d]: ctrl %h ir %h want %h ir 0251", i, ctrl(), ir_out, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    run_fetch(16'h1305);
    compared++;
    if (ir_out !== 16'h1305) begin
      mismatched++; $display("FAIL fetch_capture: ir %h want 1305", ir_out);
    end
    tick();
    want = mk(0, 0, 0, 1, 0, 1, 0, 1, 6'h01);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL andi_exec: got %h want %h", ctrl(), want);
    end
    tick();
  endtask

  task automatic test_addu();
    run_fetch(16'h0361);
    tick();
    psr_flags = 16'h0000;
    #1;
    want = mk(0, 0, 0, 1, 0, 1, 0, 0, 6'h06);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL addu_exec: got %h want %h", ctrl(), want);
    end
    tick();
    compared++;
    if (psr !== 16'h0021) begin
      mismatched++; $display("FAIL addu_psr: got %h want 0021", psr);
    end
  endtask

  task automatic test_subi();
    run_fetch(16'h9203);
    tick();
    psr_flags = 16'h00C4;
    #1;
    want = mk(0, 0, 0, 1, 0, 1, 0, 1, 6'h09);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL subi_exec: got %h want %h", ctrl(), want);
    end
    tick();
    psr_flags = 16'h0000;
    compared++;
    if (psr !== 16'h0000) begin
      mismatched++; $display("FAIL subi_psr: got %h want 0000", psr);
    end
  endtask

  task automatic test_cmp_branch();
    logic [15:0] br_instr [8] = '{16'hC005, 16'hC105, 16'hCC10, 16'hCD10,
                                  16'h4EC3, 16'h42C3, 16'h44C3, 16'h4FC3};
    logic [1:0]  br_src   [8] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
    // CMP R2,R1 with only Z set.
    run_fetch(16'h02B1);
    tick();
    psr_flags = 16'h0040;
    #1;
    want = mk(0, 0, 0, 0, 0, 1, 0, 0, 6'h0B);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL cmp_exec: got %h want %h", ctrl(), want);
    end
    tick();
    psr_flags = 16'h0000;
    compared++;
    if (psr !== 16'h0040) begin
      mismatched++; $display("FAIL cmp_psr: got %h want 0040", psr);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        // CMPI with N and L set: psr becomes N|L, Z cleared.
        run_fetch(16'hB105);
        tick();
        psr_flags = 16'h0084;
        #1;
        want = mk(0, 0, 0, 0, 0, 1, 0, 1, 6'h0B);
        compared++;
        if (ctrl() !== want) begin
          mismatched++; $display("FAIL cmpi_exec: got %h want %h", ctrl(), want);
        end
        tick();
        psr_flags = 16'h0000;
        compared++;
        if (psr !== 16'h0084) begin
          mismatched++; $display("FAIL cmpi_psr: got %h want 0084", psr);
        end
      end
      run_fetch(br_instr[i]);
      tick();
      want = mk(0, 0, 0, 0, 0, 1, br_src[i], 0, 0);
      compared++;
      if (ctrl() !== want) begin
        mismatched++; $display("FAIL branch_%h: got %h want %h", br_instr[i], ctrl(), want);
      end
      tick();
    end
  endtask

  task automatic test_nop();
    run_fetch(16'h7123);
    want = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL nop_decode: got %h want %h", ctrl(), want);
    end
    tick();
    compared++;
    if (ctrl() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++; $display("FAIL nop_refetch: got %h want %h", ctrl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_load_stor();
    run_fetch(16'h4304);
    compared++;
    if (ctrl() !== 17'd0) begin
      mismatched++; $display("FAIL load_decode: got %h want 0", ctrl());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      want = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
      compared++;
      if (ctrl() !== want || ra_addr !== 4'd3 || rb_addr !== 4'd4) begin
        mismatched++; $display("FAIL load_wait[%0d]: ctrl %h ra %0d rb %0d want %h ra 3 rb 4", i, ctrl(), ra_addr, rb_addr, want);
      end
    end
    mem_ready = 1'b1;
    #1;
    want = mk(1, 0, 1, 1, 2'd1, 1, 0, 0, 0);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL load_ready: got %h want %h", ctrl(), want);
    end
    tick();
    mem_ready = 1'b0;
    compared++;
    if (ctrl() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++; $display("FAIL load_refetch: got %h want %h", ctrl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    run_fetch(16'h4344);
    tick();
    mem_ready = 1'b1;
    #1;
    want = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL stor_ready: got %h want %h", ctrl(), want);
    end
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_jal();
    run_fetch(16'h4E83);
    tick();
    want = mk(0, 0, 0, 1, 2'd2, 1, 2'd2, 0, 0);
    compared++;
    if (ctrl() !== want) begin
      mismatched++; $display("FAIL jal_branch: got %h want %h", ctrl(), want);
    end
    tick();
  endtask

  task automatic test_async_reset();
    run_fetch(16'h4304);
    tick();
    compared++;
    if (ctrl() !== mk(1, 0, 1, 0, 0, 0, 0, 0, 0) || psr !== 16'h0084) begin
      mismatched++; $display("FAIL pre_reset_mem: ctrl %h psr %h want %h psr 0084", ctrl(), psr, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (ctrl() !== 17'd0 || psr !== 16'h0000 || ir_out !== 16'h0000) begin
      mismatched++; $display("FAIL async_reset: ctrl %h psr %h ir %h want all 0", ctrl(), psr, ir_out);
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
    compared++;
    if (mem_req !== 1'b0) begin
      mismatched++; $display("FAIL rerelease_no_req: mem_req %b want 0", mem_req);
    end
    tick();
    compared++;
    if (ctrl() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++; $display("FAIL rerelease_fetch: got %h want %h", ctrl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    reset     = 1'b0;
    instr     = 16'h0000;
    mem_ready = 1'b0;
    psr_flags = 16'h0000;
    test_reset();
    test_fetch_wait();
    test_addu();
    test_subi();
    test_cmp_branch();
    test_nop();
    test_load_stor();
    test_jal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control FSM for the 16-bit CR16-style datapath.
- Fetches an instruction, decodes it, and drives alu_cont and the register-file, immediate, writeback and PC selects.
- Runs the memory request/ready handshake for fetch, LOAD and STOR.
- Owns the architectural PSR register. It latches the ALU's combinational psr_flags selectively and evaluates Jcond/Bcond from the latched flags.

Parameters:
WIDTH, 16, datapath/instruction width
ALU_CONT_BITS, 6, width of alu_cont
REG_ADDR_BITS, 4, register index width (16 registers)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  WIDTH  memory read data, captured as instruction in FETCH
mem_ready  in  1  memory completes current request this cycle
psr_flags  in  WIDTH  combinational flags from ALU: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N
mem_req  out  1  memory request valid
mem_we  out  1  write (STOR) when 1
addr_sel  out  1  0: address = PC, 1: address = R[rb_addr]
ir_out  out  WIDTH  instruction register
alu_cont  out  ALU_CONT_BITS  ALU operation select
imm_sel  out  1  ALU b operand = sign-extended ir[7:0] (zero-extended for ANDI/ORI/XORI)
ra_addr  out  REG_ADDR_BITS  = ir[11:8] (Rdest)
rb_addr  out  REG_ADDR_BITS  = ir[3:0] (Rsrc/Raddr)
reg_write  out  1  register file write strobe
wb_sel  out  2  0: ALU, 1: memory data, 2: PC+1
pc_en  out  1  PC update strobe
pc_src  out  2  0: PC+1, 1: PC+sext(disp8), 2: R[rb_addr]
psr  out  WIDTH  latched PSR, same bit layout as psr_flags

Behaviour:
Reset (async, reset=0):
- State is FETCH.
- ir_out, psr and all strobes/selects are 0.
- mem_req rises one clk edge after reset deasserts.

States and transitions:
- FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - Holds until mem_ready=1.
  - On that edge: ir_out <= instr, go to DECODE.
  - mem_ready=0 holds indefinitely; no timeout.
- DECODE: one cycle with no strobes.
  - Register-register ALU ops, immediate ALU ops, and LUI go to EXEC.
  - LOAD and STOR go to MEM.
  - Jcond, Bcond and JAL go to BRANCH.
  - Anything else is treated as a NOP and goes to FETCH with pc_en=1, pc_src=0.
- EXEC: one cycle.
  - alu_cont is valid and reg_write=1 with wb_sel=0.
  - Exception: CMP/CMPI do not write a register.
  - pc_en=1, pc_src=0. Next state FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STOR.
  - Holds until mem_ready=1.
  - On that cycle LOAD asserts reg_write=1, wb_sel=1.
  - pc_en=1, pc_src=0. Next state FETCH.
- BRANCH: one cycle, then FETCH.
  - Bcond: pc_en=1, pc_src=1 if the condition is true, else pc_src=0.
  - Jcond: pc_en=1, pc_src=2 if true, else 0.
  - JAL: unconditional. reg_write=1, wb_sel=2, pc_src=2.

Latency: ALU op 3 cycles, branch 3, LOAD/STOR 3, plus one cycle per FETCH or MEM wait.

Decode (op = ir[15:12], ext = ir[7:4]):
- op 0000: register-register. alu_cont = {2'b00, ext} for ext in {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 0110 ADDU, 1001 SUB, 1011 CMP, 1101 MOV}; other ext values are NOP.
- op in {0001,0010,0011,0101,0110,1001,1011,1101}: immediate form. alu_cont = {2'b00, op}, imm_sel=1.
- op 1111: LUI. alu_cont = 6'b111111, imm_sel=1.
- op 0100: ext 0000 LOAD, 0100 STOR, 1000 JAL, 1100 Jcond (condition in ir[11:8]).
- op 1100: Bcond (condition ir[11:8], disp ir[7:0]).
- alu_cont is 0 in all other states.

PSR update (on the EXEC edge only):
- ADD/ADDI/SUB/SUBI: load C and F from psr_flags.
- CMP/CMPI: load N, Z and L.
- All other bits and all other ops leave psr unchanged.
- ADDU never changes psr.

Conditions (ir[11:8]):
- 0 EQ (Z), 1 NE (!Z)
- 2 CS (C), 3 CC (!C)
- 4 HI (L), 5 LS (!L)
- 6 GT (N), 7 LE (!N)
- 8 FS (F), 9 FC (!F)
- A LO (!L & !Z), B HS (L | Z)
- C LT (!N & !Z), D GE (N | Z)
- E UC (always true), F never true

Reset asserted mid-operation (including mid-handshake) aborts immediately: mem_req drops asynchronously and no write strobe remains asserted.

Test Plan:
- Reset: hold reset=0 for 3 clks, then release; provide instr=16'h0251 (ADD R2,R1) with mem_ready=1 -> mem_req rises 1 clk after release; reg_write pulses 2 clks after fetch with alu_cont=6'b000101, ra=2, rb=1; psr C/F load from psr_flags.
- Fetch wait: hold mem_ready=0 for 5 clks in FETCH -> mem_req stays 1, ir_out unchanged, no strobes; on the mem_ready edge ir_out <= instr.
- CMP then branch: CMP with psr_flags=16'h0040 (Z), then Bcond EQ 16'hC005 -> psr=16'h0040, pc_en=1, pc_src=1. Repeat with NE 16'hC105 -> pc_src=0.
- ADDU flag isolation: psr=16'h0021, execute ADDU with psr_flags=0 -> psr stays 16'h0021, reg_write=1.
- LOAD/STOR: LOAD 16'h4304 with mem_ready delayed 2 clks -> addr_sel=1, mem_we=0, reg_write with wb_sel=1 only on the ready cycle. STOR -> mem_we=1, reg_write=0.
- JAL and async reset: JAL -> reg_write=1, wb_sel=2, pc_src=2. Assert reset in MEM with mem_req=1 -> mem_req=0 before the next clk edge, state FETCH, psr=0.
